// File: rtl/m_multicycle_load_store.sv
// ---------------------------------------------------------------------------
// m_multicycle_load_store
//
// Multi-cycle RV32I-subset core (LUI, ADDI, ADD, SUB, LB/LH/LW/LBU/LHU,
// SB/SH/SW). Each instruction walks FETCH -> DECODE -> EXEC -> [MEM] -> [WB].
// There is no overlap between instructions, so DECODE always sees every
// register write of earlier instructions. A write to register HALT_REG
// retires normally and then parks the core in HALT. An illegal encoding
// parks it in FAULT. Both states are left only through reset.
//
// Instruction and data memories are internal word arrays (r_imem, r_dmem).
// Nothing in the design writes r_imem. It is preloaded from outside through
// hierarchical references. Reset leaves both memories untouched.
//
// Build option:
//   MLS_MISALIGN_TRAP_EN  defined   : a misaligned halfword/word access
//                                     faults (w_fault = 2) with no memory
//                                     access.
//                         undefined : the address is force-aligned and the
//                                     access proceeds normally.
//
// Ports:
//   w_clock    in   1   rising-edge clock
//   w_reset    in   1   asynchronous active-high reset
//   w_pc       out  32  current PC (RESET_PC after reset)
//   w_state    out  3   FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 HALT=5 FAULT=6
//   w_retire   out  1   high during the final cycle of a retired instruction
//   w_halt     out  1   high in HALT or FAULT
//   w_fault    out  2   0 none, 1 illegal, 2 misaligned (sticky)
//   w_dbg_ra   in   5   debug register-file read address
//   w_dbg_rd   out  32  combinational x[w_dbg_ra] (x0 reads 0)
// ---------------------------------------------------------------------------
module m_multicycle_load_store #(
    parameter int unsigned IMEM_DEPTH = 64,
    parameter int unsigned DMEM_DEPTH = 64,
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter int unsigned HALT_REG   = 30
) (
    input  logic        w_clock,
    input  logic        w_reset,
    output logic [31:0] w_pc,
    output logic [2:0]  w_state,
    output logic        w_retire,
    output logic        w_halt,
    output logic [1:0]  w_fault,
    input  logic [4:0]  w_dbg_ra,
    output logic [31:0] w_dbg_rd
);

    localparam int unsigned IAW = $clog2(IMEM_DEPTH);
    localparam int unsigned DAW = $clog2(DMEM_DEPTH);

    localparam logic [6:0] OP_LUI   = 7'h37;
    localparam logic [6:0] OP_IMM   = 7'h13;
    localparam logic [6:0] OP_REG   = 7'h33;
    localparam logic [6:0] OP_LOAD  = 7'h03;
    localparam logic [6:0] OP_STORE = 7'h23;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5,
        FAULT  = 3'd6
    } state_t;

    // Memories (contents survive reset)
    logic [31:0] r_imem [IMEM_DEPTH];
    logic [31:0] r_dmem [DMEM_DEPTH];

    // Architectural and internal state
    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] imm;
    logic [31:0] alu_out;
    logic [31:0] mdr;
    logic [1:0]  fault;
    logic [31:0] regs [32];

    // -----------------------------------------------------------------------
    // Instruction field decode (from IR, valid from DECODE onwards)
    // -----------------------------------------------------------------------
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] funct7;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign funct7 = ir[31:25];

    logic is_lui;
    logic is_addi;
    logic is_add;
    logic is_sub;
    logic is_load;
    logic is_store;
    logic is_mem;
    logic legal;

    always_comb begin
        is_lui   = (opcode == OP_LUI);
        is_addi  = (opcode == OP_IMM) && (funct3 == 3'b000);
        is_add   = (opcode == OP_REG) && (funct3 == 3'b000) && (funct7 == 7'h00);
        is_sub   = (opcode == OP_REG) && (funct3 == 3'b000) && (funct7 == 7'h20);
        is_load  = 1'b0;
        is_store = 1'b0;
        if (opcode == OP_LOAD) begin
            case (funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: is_load = 1'b1;
                default:                                is_load = 1'b0;
            endcase
        end
        if (opcode == OP_STORE) begin
            is_store = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        end
        is_mem = is_load || is_store;
        legal  = is_lui || is_addi || is_add || is_sub || is_load || is_store;
    end

    // Immediate selection: U for LUI, S for stores, I for everything else
    logic [31:0] imm_dec;

    always_comb begin
        imm_dec = {{20{ir[31]}}, ir[31:20]};
        if (is_lui) begin
            imm_dec = {ir[31:12], 12'h000};
        end else if (is_store) begin
            imm_dec = {{20{ir[31]}}, ir[31:25], ir[11:7]};
        end
    end

    // Register-file reads
    logic [31:0] rf_rs1;
    logic [31:0] rf_rs2;

    assign rf_rs1   = (rs1 == 5'd0) ? '0 : regs[rs1];
    assign rf_rs2   = (rs2 == 5'd0) ? '0 : regs[rs2];
    assign w_dbg_rd = (w_dbg_ra == 5'd0) ? '0 : regs[w_dbg_ra];

    // -----------------------------------------------------------------------
    // EXEC: ALU and address alignment
    // -----------------------------------------------------------------------
    logic [31:0] alu_res;
    logic        acc_half;
    logic        acc_word;
    logic        misaligned;
    logic [31:0] addr_aligned;

    always_comb begin
        alu_res = op_a + imm;
        if (is_lui) begin
            alu_res = imm;
        end else if (is_add) begin
            alu_res = op_a + op_b;
        end else if (is_sub) begin
            alu_res = op_a - op_b;
        end
    end

    // funct3[1:0] encodes access width for both loads and stores
    // (00 byte, 01 halfword, 10 word); bit 2 only selects zero extension.
    assign acc_half = is_mem && (funct3[1:0] == 2'b01);
    assign acc_word = is_mem && (funct3[1:0] == 2'b10);

    always_comb begin
        misaligned   = 1'b0;
        addr_aligned = alu_res;
        if (acc_half) begin
            misaligned   = alu_res[0];
            addr_aligned = {alu_res[31:1], 1'b0};
        end else if (acc_word) begin
            misaligned   = |alu_res[1:0];
            addr_aligned = {alu_res[31:2], 2'b00};
        end
    end

    logic trap_misaligned;
`ifdef MLS_MISALIGN_TRAP_EN
    assign trap_misaligned = misaligned;
`else
    assign trap_misaligned = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // MEM: lane extraction for loads, lane masking for stores.
    // ALU_OUT already holds an aligned address when the access reaches MEM.
    // -----------------------------------------------------------------------
    logic [DAW-1:0] dmem_idx;
    logic [1:0]     lane;
    logic [31:0]    rd_word;
    logic [31:0]    rd_shift;
    logic [31:0]    load_val;
    logic [3:0]     st_mask;
    logic [31:0]    st_data;
    logic           mem_we;

    assign dmem_idx = alu_out[DAW+1:2];
    assign lane     = alu_out[1:0];
    assign rd_word  = r_dmem[dmem_idx];
    assign rd_shift = rd_word >> {lane, 3'b000};

    always_comb begin
        case (funct3)
            3'b000:  load_val = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  load_val = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b100:  load_val = {24'h000000, rd_shift[7:0]};
            3'b101:  load_val = {16'h0000, rd_shift[15:0]};
            default: load_val = rd_word;
        endcase
    end

    always_comb begin
        case (funct3[1:0])
            2'b00: begin
                st_data = {4{op_b[7:0]}};
                st_mask = 4'b0001 << lane;
            end
            2'b01: begin
                st_data = {2{op_b[15:0]}};
                st_mask = 4'b0011 << {lane[1], 1'b0};
            end
            default: begin
                st_data = op_b;
                st_mask = 4'b1111;
            end
        endcase
    end

    assign mem_we = (state == MEM) && is_store;

    // The reset term keeps a store from landing on an edge where reset is
    // asserted even if it coincides with the clock edge.
    always_ff @(posedge w_clock) begin
        if (mem_we && !w_reset) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (st_mask[i]) begin
                    r_dmem[dmem_idx][8*i +: 8] <= st_data[8*i +: 8];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // FSM next state and per-state strobes
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        w_retire   = 1'b0;
        case (state)
            FETCH:  state_next = DECODE;
            DECODE: state_next = legal ? EXEC : FAULT;
            EXEC: begin
                if (!is_mem) begin
                    state_next = WB;
                end else if (trap_misaligned) begin
                    state_next = FAULT;
                end else begin
                    state_next = MEM;
                end
            end
            MEM: begin
                if (is_load) begin
                    state_next = WB;
                end else begin
                    state_next = FETCH;
                    w_retire   = 1'b1;
                end
            end
            WB: begin
                w_retire   = 1'b1;
                state_next = (rd == 5'(HALT_REG)) ? HALT : FETCH;
            end
            HALT:    state_next = HALT;
            FAULT:   state_next = FAULT;
            default: state_next = FETCH;
        endcase
    end

    // -----------------------------------------------------------------------
    // State register and datapath latches
    // -----------------------------------------------------------------------
    always_ff @(posedge w_clock or posedge w_reset) begin
        if (w_reset) begin
            state   <= FETCH;
            pc      <= RESET_PC;
            ir      <= '0;
            op_a    <= '0;
            op_b    <= '0;
            imm     <= '0;
            alu_out <= '0;
            mdr     <= '0;
            fault   <= '0;
            for (int unsigned i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else begin
            state <= state_next;
            case (state)
                FETCH: ir <= r_imem[pc[IAW+1:2]];
                DECODE: begin
                    op_a <= rf_rs1;
                    op_b <= rf_rs2;
                    imm  <= imm_dec;
                    if (!legal) begin
                        fault <= 2'd1;
                    end
                end
                EXEC: begin
                    alu_out <= misaligned ? addr_aligned : alu_res;
                    if (trap_misaligned) begin
                        fault <= 2'd2;
                    end
                end
                MEM: begin
                    if (is_load) begin
                        mdr <= load_val;
                    end else begin
                        pc <= pc + 32'd4;
                    end
                end
                WB: begin
                    if (rd != 5'd0) begin
                        regs[rd] <= is_load ? mdr : alu_out;
                    end
                    pc <= pc + 32'd4;
                end
                default: ;
            endcase
        end
    end

    assign w_pc    = pc;
    assign w_state = state;
    assign w_halt  = (state == HALT) || (state == FAULT);
    assign w_fault = fault;

endmodule

// File: tb/tb_m_multicycle_load_store.sv
// ---------------------------------------------------------------------------
// tb_m_multicycle_load_store
//
// Scoreboard bench for m_multicycle_load_store. For each program, an
// instruction-level reference model produces the ordered list of retirements
// (PC, retire cycle, written register or memory word). A monitor pops one
// entry on every w_retire and compares. After halt, the bench checks the
// final PC, fault code, halt cycle, full register file and data memory.
// ---------------------------------------------------------------------------
module tb_m_multicycle_load_store;

    localparam int unsigned IMEM_D = 64;
    localparam int unsigned DMEM_D = 64;
    localparam int unsigned HALT_R = 30;

    logic        w_clock = 1'b0;
    logic        w_reset = 1'b1;
    logic [31:0] w_pc;
    logic [2:0]  w_state;
    logic        w_retire;
    logic        w_halt;
    logic [1:0]  w_fault;
    logic [4:0]  w_dbg_ra = '0;
    logic [31:0] w_dbg_rd;

    m_multicycle_load_store #(
        .IMEM_DEPTH(IMEM_D),
        .DMEM_DEPTH(DMEM_D),
        .RESET_PC  (32'h0),
        .HALT_REG  (HALT_R)
    ) dut (
        .w_clock (w_clock),
        .w_reset (w_reset),
        .w_pc    (w_pc),
        .w_state (w_state),
        .w_retire(w_retire),
        .w_halt  (w_halt),
        .w_fault (w_fault),
        .w_dbg_ra(w_dbg_ra),
        .w_dbg_rd(w_dbg_rd)
    );

    always #5 w_clock = ~w_clock;

    int unsigned cyc = 0;
    int unsigned t0  = 0;
    always @(posedge w_clock) cyc++;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- encoders ----------------
    function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] r1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {im, r1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] im, input logic [4:0] r2,
                                          input logic [4:0] r1, input logic [2:0] f3);
        return {im[11:5], r2, r1, f3, im[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] r2,
                                          input logic [4:0] r1, input logic [4:0] rd);
        return {f7, r2, r1, 3'b000, rd, 7'h33};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] im, input logic [4:0] rd);
        return {im, rd, 7'h37};
    endfunction

    // ---------------- program / model state ----------------
    logic [31:0] prog [$];
    logic [31:0] init_mem [DMEM_D];
    logic [31:0] mimem [IMEM_D];
    logic [31:0] mmem [DMEM_D];
    logic [31:0] mregs [32];
    logic [31:0] exp_pc;
    logic [1:0]  exp_fault;
    int          exp_halt_cyc;

    typedef struct {
        logic [31:0] pc;
        int          kind;   // 0 register write, 1 memory word
        int          idx;
        logic [31:0] val;
        int          cyc;
    } exp_t;
    exp_t sb [$];
    bit   mon_en = 1'b0;

    task automatic add(input logic [31:0] w);
        prog.push_back(w);
    endtask

    // Instruction-level interpreter: one iteration per instruction.
    task automatic model_run();
        int unsigned acc;
        int unsigned sz;
        int unsigned wi;
        int unsigned sh;
        int unsigned lat;
        logic [31:0] ins, a, b, val, addr, w, mpc;
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        logic [4:0]  rd;
        bit          lg, ld, st;
        exp_t        e;
        acc = 0;
        mpc = 32'h0;
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        for (int i = 0; i < DMEM_D; i++) mmem[i] = init_mem[i];
        exp_fault    = 2'd0;
        exp_halt_cyc = -1;
        exp_pc       = 32'h0;
        addr         = '0;
        for (int step = 0; step < 256; step++) begin
            ins = mimem[(mpc / 4) % IMEM_D];
            op  = ins[6:0];
            rd  = ins[11:7];
            f3  = ins[14:12];
            f7  = ins[31:25];
            a   = mregs[ins[19:15]];
            b   = mregs[ins[24:20]];
            lg  = 0; ld = 0; st = 0;
            val = '0;
            case (op)
                7'h37: begin lg = 1; val = {ins[31:12], 12'h000}; end
                7'h13: if (f3 == 0) begin lg = 1; val = a + {{20{ins[31]}}, ins[31:20]}; end
                7'h33: begin
                    if (f3 == 0 && f7 == 7'h00) begin lg = 1; val = a + b; end
                    if (f3 == 0 && f7 == 7'h20) begin lg = 1; val = a - b; end
                end
                7'h03: if (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) begin
                    lg = 1; ld = 1; addr = a + {{20{ins[31]}}, ins[31:20]};
                end
                7'h23: if (f3 <= 3'd2) begin
                    lg = 1; st = 1; addr = a + {{20{ins[31]}}, ins[31:25], ins[11:7]};
                end
                default: ;
            endcase
            if (!lg) begin
                exp_fault = 2'd1; exp_halt_cyc = int'(acc) + 2; exp_pc = mpc;
                return;
            end
            wi = 0; sh = 0; sz = 0;
            if (ld || st) begin
                sz = 1 << f3[1:0];
                if (addr % sz != 0) begin
`ifdef MLS_MISALIGN_TRAP_EN
                    exp_fault = 2'd2; exp_halt_cyc = int'(acc) + 3; exp_pc = mpc;
                    return;
`else
                    addr = addr - (addr % sz);
`endif
                end
                wi = (addr / 4) % DMEM_D;
                sh = (addr % 4) * 8;
            end
            if (st) begin
                w = mmem[wi];
                for (int k = 0; k < int'(sz); k++) w[sh + 8*k +: 8] = b[8*k +: 8];
                mmem[wi] = w;
                e = '{pc: mpc, kind: 1, idx: int'(wi), val: w, cyc: int'(acc) + 4};
                sb.push_back(e);
                acc += 4; mpc += 4;
                continue;
            end
            lat = 4;
            if (ld) begin
                lat = 5;
                val = mmem[wi] >> sh;
                if (sz == 1) val = (!f3[2] && val[7])  ? (val | 32'hFFFFFF00) : (val & 32'h000000FF);
                if (sz == 2) val = (!f3[2] && val[15]) ? (val | 32'hFFFF0000) : (val & 32'h0000FFFF);
            end
            if (rd != 0) mregs[rd] = val;
            e = '{pc: mpc, kind: 0, idx: int'(rd), val: mregs[rd], cyc: int'(acc + lat)};
            sb.push_back(e);
            acc += lat; mpc += 4;
            if (rd == 5'(HALT_R)) begin
                exp_halt_cyc = int'(acc); exp_pc = mpc;
                return;
            end
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge w_clock) begin
        if (mon_en && w_retire) begin
            if (sb.size() == 0) begin
                check("unexpected_retire", w_pc, 32'hFFFFFFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("retire_pc", w_pc, e.pc);
                check("retire_cycle", 32'(cyc - t0 + 1), 32'(e.cyc));
                @(posedge w_clock);
                #1;
                if (e.kind == 0) begin
                    w_dbg_ra = 5'(e.idx);
                    #1;
                    check("wb_value", w_dbg_rd, e.val);
                end else begin
                    check("store_word", dut.r_dmem[e.idx], e.val);
                end
            end
        end
    end

    // ---------------- run helpers ----------------
    task automatic load_mem();
        w_reset = 1'b1;
        for (int i = 0; i < IMEM_D; i++) begin
            mimem[i]      = (i < prog.size()) ? prog[i] : 32'h0;
            dut.r_imem[i] = mimem[i];
        end
        for (int i = 0; i < DMEM_D; i++) dut.r_dmem[i] = init_mem[i];
    endtask

    task automatic reset_and_start(input bit en);
        w_reset = 1'b1;
        mon_en  = 1'b0;
        sb.delete();
        repeat (2) @(posedge w_clock);
        @(negedge w_clock);
        check("rst_pc", w_pc, 32'h0);
        check("rst_state", 32'(w_state), 32'd0);
        check("rst_retire", 32'(w_retire), 32'd0);
        check("rst_halt", 32'(w_halt), 32'd0);
        check("rst_fault", 32'(w_fault), 32'd0);
        model_run();
        w_reset = 1'b0;
        t0      = cyc;
        mon_en  = en;
    endtask

    task automatic wait_done(input string nm, output int hc);
        int unsigned n;
        n = 0;
        while (w_halt !== 1'b1 && n < 2000) begin
            @(negedge w_clock);
            n++;
        end
        hc = int'(cyc - t0);
        mon_en = 1'b0;
        check({nm, "_halt"}, 32'(w_halt), 32'd1);
        check({nm, "_halt_cycle"}, 32'(hc), 32'(exp_halt_cyc));
        check({nm, "_state"}, 32'(w_state), (exp_fault != 0) ? 32'd6 : 32'd5);
        check({nm, "_fault"}, 32'(w_fault), 32'(exp_fault));
        check({nm, "_pc"}, w_pc, exp_pc);
        check({nm, "_sb_empty"}, 32'(sb.size()), 32'd0);
        for (int i = 0; i < 32; i++) begin
            w_dbg_ra = 5'(i);
            #1;
            check($sformatf("%s_x%0d", nm, i), w_dbg_rd, mregs[i]);
        end
        for (int i = 0; i < DMEM_D; i++) check($sformatf("%s_dmem%0d", nm, i), dut.r_dmem[i], mmem[i]);
        @(negedge w_clock);
        check({nm, "_pc_hold"}, w_pc, exp_pc);
        check({nm, "_retire_idle"}, 32'(w_retire), 32'd0);
    endtask

    task automatic run_test(input string nm, output int hc);
        load_mem();
        reset_and_start(1'b1);
        wait_done(nm, hc);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < DMEM_D; i++) init_mem[i] = 32'h0;
    endtask

    task automatic gen_random();
        prog.delete();
        for (int k = 0; k < 14; k++) begin
            int unsigned sel, t;
            logic [4:0]  rd, r1, r2;
            logic [2:0]  f3;
            logic [11:0] off;
            sel = $urandom_range(0, 8);
            rd  = 5'($urandom_range(0, 7));
            r1  = 5'($urandom_range(0, 7));
            r2  = 5'($urandom_range(0, 7));
            off = 12'($urandom_range(0, 255));
            t   = $urandom_range(0, 4);
            f3  = (t < 3) ? 3'(t) : 3'(t + 1);
            if (sel >= 7) f3 = 3'($urandom_range(0, 2));
            if (sel >= 5) begin
                if ($urandom_range(0, 1) == 0) r1 = 5'd0;
                if ($urandom_range(0, 3) != 0) begin
                    if (f3[1:0] == 2'b10) off[1:0] = 2'b00;
                    if (f3[1:0] == 2'b01) off[0]   = 1'b0;
                end
            end
            case (sel)
                0:       add(enc_u(20'($urandom), rd));
                1, 2:    add(enc_i(12'($urandom), r1, 3'd0, rd, 7'h13));
                3:       add(enc_r(7'h00, r2, r1, rd));
                4:       add(enc_r(7'h20, r2, r1, rd));
                5, 6:    add(enc_i(off, r1, f3, rd, 7'h03));
                default: add(enc_s(off, r2, r1, f3));
            endcase
        end
        add(enc_i(12'($urandom_range(1, 100)), 5'd0, 3'd0, 5'(HALT_R), 7'h13));
        for (int i = 0; i < DMEM_D; i++) init_mem[i] = $urandom;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int hc;
        int unsigned n;

        // Word load/store
        prog.delete(); clear_mem();
        add(enc_i(12'd7, 5'd0, 3'd0, 5'd1, 7'h13));
        add(enc_s(12'd8, 5'd1, 5'd0, 3'd2));
        add(enc_i(12'd8, 5'd0, 3'd2, 5'd2, 7'h03));
        add(enc_i(12'd1, 5'd0, 3'd0, 5'd30, 7'h13));
        run_test("word", hc);
        check("word_halt17", 32'(hc), 32'd17);
        check("word_dmem2_lit", dut.r_dmem[2], 32'd7);
        check("word_pc_lit", w_pc, 32'h10);

        // Byte access
        prog.delete(); clear_mem();
        add(enc_i(12'hF80, 5'd0, 3'd0, 5'd1, 7'h13));
        add(enc_s(12'd5, 5'd1, 5'd0, 3'd0));
        add(enc_i(12'd5, 5'd0, 3'd0, 5'd2, 7'h03));
        add(enc_i(12'd5, 5'd0, 3'd4, 5'd3, 7'h03));
        add(enc_i(12'd1, 5'd0, 3'd0, 5'd30, 7'h13));
        run_test("byte", hc);
        check("byte_dmem1_lit", dut.r_dmem[1], 32'h00008000);

        // Halfword access, positive then negative halfword
        prog.delete(); clear_mem();
        add(enc_u(20'hABCD0, 5'd1));
        add(enc_i(12'h123, 5'd1, 3'd0, 5'd1, 7'h13));
        add(enc_s(12'd6, 5'd1, 5'd0, 3'd1));
        add(enc_i(12'd6, 5'd0, 3'd1, 5'd4, 7'h03));
        add(enc_i(12'd6, 5'd0, 3'd5, 5'd5, 7'h03));
        add(enc_u(20'h0000B, 5'd1));
        add(enc_i(12'hBCD, 5'd1, 3'd0, 5'd1, 7'h13));   // 0xB000 - 0x433 = 0xABCD
        add(enc_s(12'd6, 5'd1, 5'd0, 3'd1));
        add(enc_i(12'd6, 5'd0, 3'd1, 5'd6, 7'h03));
        add(enc_i(12'd6, 5'd0, 3'd5, 5'd7, 7'h03));
        add(enc_i(12'd1, 5'd0, 3'd0, 5'd30, 7'h13));
        run_test("half", hc);
        w_dbg_ra = 5'd6; #1;
        check("half_lh_neg_lit", w_dbg_rd, 32'hFFFFABCD);
        w_dbg_ra = 5'd7; #1;
        check("half_lhu_lit", w_dbg_rd, 32'h0000ABCD);

        // Misaligned word load
        prog.delete(); clear_mem();
        init_mem[2] = 32'hDEADBEEF;
        add(enc_i(12'd9, 5'd0, 3'd2, 5'd2, 7'h03));
        add(enc_i(12'd1, 5'd0, 3'd0, 5'd30, 7'h13));
        run_test("misalign", hc);

        // Illegal instruction after an add that targets x0
        prog.delete(); clear_mem();
        add(enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13));
        add(enc_r(7'h00, 5'd1, 5'd1, 5'd0));
        add(32'h0000006F);
        run_test("illegal", hc);
        check("illegal_fault_lit", 32'(w_fault), 32'd1);
        check("illegal_pc_lit", w_pc, 32'h8);

        // Reset asserted during MEM of the store
        prog.delete(); clear_mem();
        init_mem[2] = 32'h12345678;
        add(enc_i(12'd7, 5'd0, 3'd0, 5'd1, 7'h13));
        add(enc_s(12'd8, 5'd1, 5'd0, 3'd2));
        add(enc_i(12'd8, 5'd0, 3'd2, 5'd2, 7'h03));
        add(enc_i(12'd1, 5'd0, 3'd0, 5'd30, 7'h13));
        load_mem();
        reset_and_start(1'b0);
        n = 0;
        while (w_state !== 3'd3 && n < 50) begin
            @(negedge w_clock);
            n++;
        end
        check("rstmid_reached_mem", 32'(w_state), 32'd3);
        w_reset = 1'b1;
        #1;
        check("rstmid_pc", w_pc, 32'h0);
        check("rstmid_state", 32'(w_state), 32'd0);
        check("rstmid_halt", 32'(w_halt), 32'd0);
        @(posedge w_clock);
        #1;
        check("rstmid_dmem2", dut.r_dmem[2], 32'h12345678);
        reset_and_start(1'b1);
        wait_done("rerun", hc);

        // Random programs
        for (int r = 0; r < 6; r++) begin
            gen_random();
            run_test($sformatf("rand%0d", r), hc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

endmodule
